prog_loader_rom: RTL and testbench

Upstream instruction store for the 8-bit LED-matrix CPU. It receives a program image over a UART line and writes it into an internal 2^ADDR_W x 16 block RAM. It holds the CPU in reset while loading and releases it on a valid image. After release it serves instruction words on dout for the CPU's program-counter address.

---
 rtl/prog_loader_rom_if.sv | 17 +
 rtl/prog_loader_rom.sv | 205 ++++++++++++++++++++
 tb/tb_prog_loader_rom.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_rom_if.sv
// Bus bundle between the program loader and its CPU/UART neighbours.
interface prog_loader_rom_if #(
    parameter int ADDR_W = 11
);
    logic              uart_rx;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       dout;
    logic              cpu_rst_n;
    logic              loading;
    logic              load_done;
    logic              err;

    modport slave  (input  uart_rx, pc,
                    output dout, cpu_rst_n, loading, load_done, err);
    modport master (output uart_rx, pc,
                    input  dout, cpu_rst_n, loading, load_done, err);
endinterface

// File: rtl/prog_loader_rom.sv
// UART program loader + instruction RAM for the LED-matrix CPU.
// Frame: 0x55, LEN_H, LEN_L, 2N data bytes (low byte first), 8-bit sum.
module prog_loader_rom #(
    parameter int CLK_HZ       = 27000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 11,
    parameter int TIMEOUT_CYC  = 2700000,
    parameter bit RUN_ON_RESET = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    prog_loader_rom_if.slave   bus
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CNT_W   = $clog2(BIT_CYC + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int DEPTH   = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_DATA_LO, S_DATA_HI, S_CHECK
    } state_t;

    // receiver
    logic             r_rx_s1, r_rx_s2, r_rx_prev;
    logic             r_rx_busy;
    logic [3:0]       r_rx_phase;   // 0 start, 1..8 data, 9 stop
    logic [CNT_W-1:0] r_rx_cnt;
    logic [7:0]       r_rx_shift;
    logic             r_rx_valid;
    logic             r_rx_ferr;
    logic [7:0]       r_rx_byte;

    // loader
    state_t            r_state;
    logic [7:0]        r_len_h;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_wcnt;
    logic [7:0]        r_lo;
    logic [7:0]        r_sum;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_cpu_rst_n;
    logic              r_loading;
    logic              r_load_done;
    logic              r_err;
    logic [1:0]        r_por;
    logic [15:0]       r_dout;
    logic [15:0]       r_mem [0:DEPTH-1];

    logic [15:0]       w_len;
    logic              w_len_bad;
    logic [ADDR_W:0]   w_wnext;
    logic              w_we;
    logic              w_abort;

    assign w_len     = {r_len_h, r_rx_byte};
    assign w_len_bad = (w_len == 16'd0) || ({1'b0, w_len} > 17'(DEPTH));
    assign w_wnext   = r_wcnt + 1'b1;
    assign w_we      = r_rx_valid && (r_state == S_DATA_HI);
    // framing error or idle timeout inside a frame kills the load
    assign w_abort   = (r_state != S_IDLE) &&
                       (r_rx_ferr || (!r_rx_valid && r_to_cnt == TO_W'(TIMEOUT_CYC - 1)));

    // UART byte receiver: sync, start detect, mid-bit sampling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_phase <= '0;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_byte  <= '0;
        end else begin
            r_rx_s1    <= bus.uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_s2) begin
                    r_rx_busy  <= 1'b1;
                    r_rx_phase <= '0;
                    r_rx_cnt   <= CNT_W'(HALF - 1);
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - 1'b1;
            end else begin
                r_rx_cnt   <= CNT_W'(BIT_CYC - 1);
                r_rx_phase <= r_rx_phase + 4'd1;
                if (r_rx_phase == 4'd0) begin
                    // glitch: start bit no longer low at its centre
                    if (r_rx_s2) r_rx_busy <= 1'b0;
                end else if (r_rx_phase <= 4'd8) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                end else begin
                    r_rx_busy <= 1'b0;
                    if (r_rx_s2) begin
                        r_rx_valid <= 1'b1;
                        r_rx_byte  <= r_rx_shift;
                    end else begin
                        r_rx_ferr <= 1'b1;
                    end
                end
            end
        end
    end

    // frame parser, CPU reset control and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len_h     <= '0;
            r_len       <= '0;
            r_wcnt      <= '0;
            r_lo        <= '0;
            r_sum       <= '0;
            r_to_cnt    <= '0;
            r_cpu_rst_n <= 1'b0;
            r_loading   <= 1'b0;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
            r_por       <= '0;
        end else begin
            r_load_done <= 1'b0;
            r_por       <= {r_por[0], 1'b1};
            if (RUN_ON_RESET && r_por == 2'b01) r_cpu_rst_n <= 1'b1;

            if (r_state == S_IDLE || r_rx_valid) r_to_cnt <= '0;
            else                                 r_to_cnt <= r_to_cnt + 1'b1;

            unique case (r_state)
                S_IDLE: if (r_rx_valid && r_rx_byte == 8'h55) begin
                    r_state     <= S_LEN_H;
                    r_cpu_rst_n <= 1'b0;
                    r_loading   <= 1'b1;
                    r_err       <= 1'b0;
                    r_wcnt      <= '0;
                    r_sum       <= '0;
                end
                S_LEN_H: if (r_rx_valid) begin
                    r_len_h <= r_rx_byte;
                    r_state <= S_LEN_L;
                end
                S_LEN_L: if (r_rx_valid) begin
                    if (w_len_bad) begin
                        r_err     <= 1'b1;
                        r_loading <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_len   <= w_len[ADDR_W:0];
                        r_state <= S_DATA_LO;
                    end
                end
                S_DATA_LO: if (r_rx_valid) begin
                    r_lo    <= r_rx_byte;
                    r_sum   <= r_sum + r_rx_byte;
                    r_state <= S_DATA_HI;
                end
                S_DATA_HI: if (r_rx_valid) begin
                    r_sum   <= r_sum + r_rx_byte;
                    r_wcnt  <= w_wnext;
                    r_state <= (w_wnext == r_len) ? S_CHECK : S_DATA_LO;
                end
                S_CHECK: if (r_rx_valid) begin
                    r_loading <= 1'b0;
                    r_state   <= S_IDLE;
                    if (r_rx_byte == r_sum) begin
                        r_cpu_rst_n <= 1'b1;
                        r_load_done <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_abort) begin
                r_err     <= 1'b1;
                r_loading <= 1'b0;
                r_state   <= S_IDLE;
            end
        end
    end

    // program store write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wcnt[ADDR_W-1:0]] <= {r_rx_byte, r_lo};
    end

    // instruction fetch, read-before-write on same-address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dout <= '0;
        else        r_dout <= r_mem[bus.pc];
    end

    assign bus.dout      = r_dout;
    assign bus.cpu_rst_n = r_cpu_rst_n;
    assign bus.loading   = r_loading;
    assign bus.load_done = r_load_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_prog_loader_rom.sv
// Directed bench for prog_loader_rom with a frame-level reference model.
module tb_prog_loader_rom;
    localparam int CLK_HZ = 1600;
    localparam int BAUD   = 100;
    localparam int BITC   = CLK_HZ / BAUD;
    localparam int AW     = 4;
    localparam int DEPTH  = 1 << AW;
    localparam int TO     = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_rom_if #(.ADDR_W(AW)) bus ();
    prog_loader_rom_if #(.ADDR_W(AW)) bus2 ();

    prog_loader_rom #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(AW),
                      .TIMEOUT_CYC(TO), .RUN_ON_RESET(1'b0))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    prog_loader_rom #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(AW),
                      .TIMEOUT_CYC(TO), .RUN_ON_RESET(1'b1))
        dut_run (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit          m_in;
    logic [7:0]  fq[$];
    bit          m_cpu, m_load, m_err;
    int          m_done;
    int          m_n;
    logic [15:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];

    function automatic void m_abort();
        m_in = 0; m_err = 1; m_load = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit ok);
        int sz;
        int s;
        if (!m_in) begin
            if (ok && b == 8'h55) begin
                m_in = 1; fq.delete(); m_err = 0; m_cpu = 0; m_load = 1;
            end
            return;
        end
        if (!ok) begin m_abort(); return; end
        fq.push_back(b);
        sz = fq.size();
        if (sz == 2) begin
            m_n = {fq[0], fq[1]};
            if (m_n == 0 || m_n > DEPTH) m_abort();
        end else if (sz > 2 && sz <= 2 + 2 * m_n) begin
            if (sz % 2 == 0) begin
                m_mem[(sz - 2) / 2 - 1] = {fq[sz-1], fq[sz-2]};
                m_vld[(sz - 2) / 2 - 1] = 1;
            end
        end else if (sz == 3 + 2 * m_n) begin
            s = 0;
            for (int i = 2; i < 2 + 2 * m_n; i++) s += fq[i];
            if (s[7:0] == b) begin
                m_in = 0; m_load = 0; m_cpu = 1; m_done++;
            end else m_abort();
        end
    endfunction

    // ---------------- continuous compare ----------------
    bit          chk_en = 0;
    bit          sweep  = 1;
    logic [AW-1:0] lit_pc = '0;
    logic [AW-1:0] pc_q;
    int          done_cnt = 0;

    always @(posedge clk) pc_q <= bus.pc;
    always @(posedge clk) if (bus.load_done === 1'b1) done_cnt <= done_cnt + 1;

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("cpu_rst_n", 32'(bus.cpu_rst_n), 32'(m_cpu));
            chk("loading",   32'(bus.loading),   32'(m_load));
            chk("err",       32'(bus.err),       32'(m_err));
            chk("load_done_idle", 32'(bus.load_done), 32'd0);
            if (m_vld[pc_q]) chk("dout", 32'(bus.dout), 32'(m_mem[pc_q]));
        end
    end

    // pc walks the memory unless a literal read pins it
    initial begin
        bus.pc = '0;
        forever begin
            @(negedge clk);
            bus.pc = sweep ? bus.pc + 1'b1 : lit_pc;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input bit stop);
        chk_en = 0;
        bus.uart_rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (BITC) @(negedge clk);
        end
        bus.uart_rx = stop;
        repeat (BITC) @(negedge clk);
        if (!stop) begin
            bus.uart_rx = 1'b1;
            repeat (BITC) @(negedge clk);
        end
        model_byte(b, stop);
        repeat (2) @(negedge clk);
        chk_en = 1;
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send_byte(f[i], 1'b1);
    endtask

    task automatic read_lit(input string name, input logic [AW-1:0] a, input logic [15:0] exp);
        sweep = 0; lit_pc = a;
        @(negedge clk);
        @(negedge clk);
        chk(name, 32'(bus.dout), 32'(exp));
        sweep = 1;
    endtask

    logic [7:0] good[$] = '{8'h55, 8'h00, 8'h03, 8'h01, 8'h00, 8'h02, 8'h01, 8'h03, 8'h02, 8'h09};
    logic [7:0] badc[$] = '{8'h55, 8'h00, 8'h03, 8'h01, 8'h00, 8'h02, 8'h01, 8'h03, 8'h02, 8'h0A};
    logic [7:0] good2[$] = '{8'h55, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};

    initial begin
        bus.uart_rx  = 1'b1;
        bus2.uart_rx = 1'b1;
        bus2.pc      = '0;
        m_in = 0; m_cpu = 0; m_load = 0; m_err = 0; m_done = 0; m_n = 0;
        foreach (m_vld[i]) m_vld[i] = 0;

        // reset state
        #23;
        chk("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        chk("rst_loading",   32'(bus.loading),   32'd0);
        chk("rst_load_done", 32'(bus.load_done), 32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_dout",      32'(bus.dout),      32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("run_on_reset_edge1", 32'(bus2.cpu_rst_n), 32'd0);
        @(posedge clk) #1;
        chk("run_on_reset_edge2", 32'(bus2.cpu_rst_n), 32'd1);
        chk("no_run_on_reset",    32'(bus.cpu_rst_n),  32'd0);
        repeat (4) @(negedge clk);
        chk_en = 1;

        // stray byte in idle is ignored
        send_byte(8'hAA, 1'b1);

        // 1: good three-word load
        send_frame(good);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_cpu", 32'(bus.cpu_rst_n), 32'd1);
        chk("t1_err", 32'(bus.err), 32'd0);
        read_lit("t1_mem0", 4'd0, 16'h0001);
        read_lit("t1_mem2", 4'd2, 16'h0203);
        read_lit("t1_mem1", 4'd1, 16'h0102);

        // 2: checksum mismatch
        send_frame(badc);
        chk("t2_err", 32'(bus.err), 32'd1);
        chk("t2_cpu", 32'(bus.cpu_rst_n), 32'd0);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        read_lit("t2_mem0", 4'd0, 16'h0001);
        read_lit("t2_mem1", 4'd1, 16'h0102);
        read_lit("t2_mem2", 4'd2, 16'h0203);

        // 3: illegal lengths, then recovery
        send_frame('{8'h55, 8'h00, 8'h00});
        chk("t3_len0_err", 32'(bus.err), 32'd1);
        chk("t3_len0_loading", 32'(bus.loading), 32'd0);
        send_frame('{8'h55, 8'h00, 8'h11});
        chk("t3_len17_err", 32'(bus.err), 32'd1);
        send_frame('{8'h55, 8'h01, 8'h00});
        chk("t3_len256_err", 32'(bus.err), 32'd1);
        send_frame(good);
        chk("t3_done_cnt", 32'(done_cnt), 32'd2);
        chk("t3_err", 32'(bus.err), 32'd0);

        // 4: idle timeout inside a frame
        send_frame('{8'h55, 8'h00, 8'h02, 8'hAA});
        chk("t4_loading_mid", 32'(bus.loading), 32'd1);
        chk_en = 0;
        repeat (TO + 10) @(negedge clk);
        m_abort();
        chk("t4_err", 32'(bus.err), 32'd1);
        chk("t4_loading", 32'(bus.loading), 32'd0);
        chk("t4_cpu", 32'(bus.cpu_rst_n), 32'd0);
        chk_en = 1;

        // 5: framing-error sync byte while running, then a real one
        send_frame(good);
        chk("t5_cpu_run", 32'(bus.cpu_rst_n), 32'd1);
        send_byte(8'h55, 1'b0);
        chk("t5_ferr_cpu", 32'(bus.cpu_rst_n), 32'd1);
        chk("t5_ferr_loading", 32'(bus.loading), 32'd0);
        send_byte(8'h55, 1'b1);
        chk("t5_sync_cpu", 32'(bus.cpu_rst_n), 32'd0);
        chk("t5_sync_loading", 32'(bus.loading), 32'd1);

        // 6: reset in DATA_HI, then reload from address 0
        send_frame('{8'h00, 8'h02, 8'h11});
        chk_en = 0;
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("t6_rst_cpu",     32'(bus.cpu_rst_n), 32'd0);
        chk("t6_rst_loading", 32'(bus.loading),   32'd0);
        chk("t6_rst_err",     32'(bus.err),       32'd0);
        chk("t6_rst_dout",    32'(bus.dout),      32'd0);
        chk("t6_rst_run_cpu", 32'(bus2.cpu_rst_n), 32'd0);
        m_in = 0; m_err = 0; m_cpu = 0; m_load = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_en = 1;
        send_frame(good2);
        chk("t6_done_cnt", 32'(done_cnt), 32'd4);
        chk("t6_cpu", 32'(bus.cpu_rst_n), 32'd1);
        read_lit("t6_mem0", 4'd0, 16'h1234);
        read_lit("t6_mem1", 4'd1, 16'h5678);
        read_lit("t6_mem2", 4'd2, 16'h0203);
        chk("model_done_cnt", 32'(done_cnt), 32'(m_done));

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
